// File: rtl/instruction_decode.sv
// ID stage: register file with WB write-through, control decode, load-use and
// branch hazard detection, in-ID branch/jump resolution and the ID/EX register.
module instruction_decode #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruccion,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              ex_mem_reg_write,
  input  logic              ex_mem_mem_read,
  input  logic [4:0]        ex_mem_write_reg,
  output logic [ADDR_W-1:0] pc_salto,
  output logic              PCSrc,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              IF_Flush,
  output logic [DATA_W-1:0] id_ex_read_data_1,
  output logic [DATA_W-1:0] id_ex_read_data_2,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [4:0]        id_ex_rs,
  output logic [4:0]        id_ex_rt,
  output logic [4:0]        id_ex_rd,
  output logic [ADDR_W-1:0] id_ex_pc,
  output logic              id_ex_reg_dst,
  output logic              id_ex_alu_src,
  output logic              id_ex_mem_read,
  output logic              id_ex_mem_write,
  output logic              id_ex_reg_write,
  output logic              id_ex_mem_to_reg,
  output logic [1:0]        id_ex_alu_op
);

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [ADDR_W-1:0] pc;
    logic              reg_dst;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [1:0]        alu_op;
  } id_ex_t;

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  id_ex_t            id_ex_q, id_ex_d;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg, uses_rt;
  logic [1:0] alu_op;
  logic is_beq, is_bne, is_j;
  logic [4:0] id_ex_dest;
  logic load_use, rs_br_haz, rt_br_haz, stall, taken;
  logic [ADDR_W-1:0] branch_tgt, jump_tgt;

  // A load in EX/MEM always writes a register, so ex_mem_reg_write covers it.
  logic unused_ex_mem_mem_read;
  assign unused_ex_mem_mem_read = ex_mem_mem_read;

  assign opcode = instruccion[31:26];
  assign rs     = instruccion[25:21];
  assign rt     = instruccion[20:16];
  assign rd     = instruccion[15:11];
  assign imm16  = instruccion[15:0];

  always_comb begin
    regs_d = regs_q;
    if (wb_reg_write && (wb_write_reg != 5'd0)) regs_d[wb_write_reg] = wb_write_data;
  end

  always_comb begin
    rs_val = regs_q[rs];
    rt_val = regs_q[rt];
    if (wb_reg_write && (wb_write_reg == rs)) rs_val = wb_write_data;
    if (wb_reg_write && (wb_write_reg == rt)) rt_val = wb_write_data;
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;
    uses_rt    = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    case (opcode)
      6'h00: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = 2'b10; uses_rt = 1'b1; end
      6'h23: begin alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
      6'h2B: begin alu_src = 1'b1; mem_write = 1'b1; uses_rt = 1'b1; end
      6'h08: begin alu_src = 1'b1; reg_write = 1'b1; end
      6'h04: begin is_beq = 1'b1; uses_rt = 1'b1; end
      6'h05: begin is_bne = 1'b1; uses_rt = 1'b1; end
      6'h02: is_j = 1'b1;
      default: ;
    endcase
  end

  assign id_ex_dest = id_ex_q.reg_dst ? id_ex_q.rd : id_ex_q.rt;

  always_comb begin
    load_use  = id_ex_q.mem_read && (id_ex_q.rt != 5'd0) &&
                ((id_ex_q.rt == rs) || (uses_rt && (id_ex_q.rt == rt)));
    rs_br_haz = (rs != 5'd0) &&
                ((id_ex_q.reg_write && (id_ex_dest == rs)) ||
                 (ex_mem_reg_write && (ex_mem_write_reg == rs)));
    rt_br_haz = (rt != 5'd0) &&
                ((id_ex_q.reg_write && (id_ex_dest == rt)) ||
                 (ex_mem_reg_write && (ex_mem_write_reg == rt)));
    stall     = load_use || ((is_beq || is_bne) && (rs_br_haz || rt_br_haz));
    taken     = !stall && ((is_beq && (rs_val == rt_val)) ||
                           (is_bne && (rs_val != rt_val)) || is_j);
  end

  assign branch_tgt = pc_in + imm16[ADDR_W-1:0];
  assign jump_tgt   = instruccion[ADDR_W-1:0];

  assign pc_salto    = is_j ? jump_tgt : branch_tgt;
  assign PCSrc       = !reset && taken;
  assign IF_Flush    = !reset && taken;
  assign PCWrite     = reset || !stall;
  assign IF_ID_Write = reset || !stall;

  // Stalls and taken branches/jumps both leave an all-zero bubble in ID/EX.
  always_comb begin
    id_ex_d = '0;
    if (!stall && !taken) begin
      id_ex_d.rd1        = rs_val;
      id_ex_d.rd2        = rt_val;
      id_ex_d.imm        = {{(DATA_W-16){imm16[15]}}, imm16};
      id_ex_d.rs         = rs;
      id_ex_d.rt         = rt;
      id_ex_d.rd         = rd;
      id_ex_d.pc         = pc_in;
      id_ex_d.reg_dst    = reg_dst;
      id_ex_d.alu_src    = alu_src;
      id_ex_d.mem_read   = mem_read;
      id_ex_d.mem_write  = mem_write;
      id_ex_d.reg_write  = reg_write;
      id_ex_d.mem_to_reg = mem_to_reg;
      id_ex_d.alu_op     = alu_op;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      id_ex_q <= '0;
    end else begin
      regs_q  <= regs_d;
      id_ex_q <= id_ex_d;
    end
  end

  assign id_ex_read_data_1 = id_ex_q.rd1;
  assign id_ex_read_data_2 = id_ex_q.rd2;
  assign id_ex_imm         = id_ex_q.imm;
  assign id_ex_rs          = id_ex_q.rs;
  assign id_ex_rt          = id_ex_q.rt;
  assign id_ex_rd          = id_ex_q.rd;
  assign id_ex_pc          = id_ex_q.pc;
  assign id_ex_reg_dst     = id_ex_q.reg_dst;
  assign id_ex_alu_src     = id_ex_q.alu_src;
  assign id_ex_mem_read    = id_ex_q.mem_read;
  assign id_ex_mem_write   = id_ex_q.mem_write;
  assign id_ex_reg_write   = id_ex_q.reg_write;
  assign id_ex_mem_to_reg  = id_ex_q.mem_to_reg;
  assign id_ex_alu_op      = id_ex_q.alu_op;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed-vector bench for instruction_decode with hand-computed expectations.
module tb_instruction_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruccion;
  logic [10:0] pc_in;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        ex_mem_reg_write;
  logic        ex_mem_mem_read;
  logic [4:0]  ex_mem_write_reg;
  logic [10:0] pc_salto;
  logic        PCSrc, PCWrite, IF_ID_Write, IF_Flush;
  logic [31:0] id_ex_read_data_1, id_ex_read_data_2, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic [10:0] id_ex_pc;
  logic        id_ex_reg_dst, id_ex_alu_src, id_ex_mem_read, id_ex_mem_write;
  logic        id_ex_reg_write, id_ex_mem_to_reg;
  logic [1:0]  id_ex_alu_op;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_decode dut (
    .clock(clock), .reset(reset), .instruccion(instruccion), .pc_in(pc_in),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_mem_write_reg(ex_mem_write_reg),
    .pc_salto(pc_salto), .PCSrc(PCSrc), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_Flush(IF_Flush),
    .id_ex_read_data_1(id_ex_read_data_1), .id_ex_read_data_2(id_ex_read_data_2),
    .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_pc(id_ex_pc), .id_ex_reg_dst(id_ex_reg_dst), .id_ex_alu_src(id_ex_alu_src),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
    .id_ex_alu_op(id_ex_alu_op)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] ctrl_bits();
    return 32'({id_ex_reg_dst, id_ex_alu_src, id_ex_mem_read, id_ex_mem_write,
                id_ex_reg_write, id_ex_mem_to_reg, id_ex_alu_op});
  endfunction

  initial begin
    reset = 1'b1;
    instruccion = {6'h02, 26'h123};
    pc_in = 11'h000;
    wb_reg_write = 1'b0; wb_write_reg = 5'd0; wb_write_data = 32'h0;
    ex_mem_reg_write = 1'b0; ex_mem_mem_read = 1'b0; ex_mem_write_reg = 5'd0;

    // reset held two cycles; a jump in IF/ID must not redirect fetch
    step();
    check("rst_pcsrc", 32'(PCSrc), 32'd0);
    check("rst_flush", 32'(IF_Flush), 32'd0);
    check("rst_pcwrite", 32'(PCWrite), 32'd1);
    step();
    reset = 1'b0;
    instruccion = 32'h0;
    #2;
    check("post_rst_pcwrite", 32'(PCWrite), 32'd1);
    check("post_rst_ifid", 32'(IF_ID_Write), 32'd1);

    for (int i = 0; i < 16; i++) begin
      instruccion = r_type(5'(2*i), 5'(2*i+1), 5'd0);
      step();
      check($sformatf("rst_reg%0d", 2*i), id_ex_read_data_1, 32'h0);
      check($sformatf("rst_reg%0d", 2*i+1), id_ex_read_data_2, 32'h0);
    end

    // WB write-through bypass and $0 immutability
    instruccion = r_type(5'd5, 5'd0, 5'd3);
    wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'h1234;
    step();
    check("bypass_rs", id_ex_read_data_1, 32'h1234);
    check("rtype_rd", 32'(id_ex_rd), 32'd3);
    check("rtype_ctrl", ctrl_bits(), 32'b1000_1010);
    instruccion = r_type(5'd0, 5'd5, 5'd1);
    wb_write_reg = 5'd0; wb_write_data = 32'hDEAD;
    step();
    check("r0_bypass", id_ex_read_data_1, 32'h0);
    check("reg5_stored", id_ex_read_data_2, 32'h1234);
    wb_reg_write = 1'b0;
    instruccion = r_type(5'd0, 5'd0, 5'd1);
    step();
    check("r0_reads_zero", id_ex_read_data_1, 32'h0);

    instruccion = 32'h0;
    wb_reg_write = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'd7;
    step();
    wb_write_reg = 5'd2;
    step();
    wb_reg_write = 1'b0;

    // sw decode with negative offset, then an unknown opcode
    instruccion = i_type(6'h2B, 5'd1, 5'd2, 16'hFFFC);
    step();
    check("sw_ctrl", ctrl_bits(), 32'b0101_0000);
    check("sw_imm", id_ex_imm, 32'hFFFF_FFFC);
    check("sw_rt_val", id_ex_read_data_2, 32'd7);
    instruccion = 32'hFFFF_FFFF;
    step();
    check("bad_op_ctrl", ctrl_bits(), 32'h0);

    // load-use: one stall cycle, one bubble, then the dependent add
    instruccion = i_type(6'h23, 5'd1, 5'd2, 16'h0000);
    pc_in = 11'h055;
    #2;
    check("lw_no_stall", 32'(PCWrite), 32'd1);
    step();
    check("lw_ctrl", ctrl_bits(), 32'b0110_1100);
    check("lw_rt", 32'(id_ex_rt), 32'd2);
    check("lw_pc", 32'(id_ex_pc), 32'h055);
    check("lw_rs_val", id_ex_read_data_1, 32'd7);
    instruccion = r_type(5'd2, 5'd3, 5'd4);
    #2;
    check("lu_pcwrite", 32'(PCWrite), 32'd0);
    check("lu_ifid", 32'(IF_ID_Write), 32'd0);
    check("lu_pcsrc", 32'(PCSrc), 32'd0);
    step();
    check("lu_bubble", ctrl_bits(), 32'h0);
    #2;
    check("lu_release", 32'(PCWrite), 32'd1);
    step();
    check("lu_add_ctrl", ctrl_bits(), 32'b1000_1010);
    check("lu_add_regs", 32'({id_ex_rs, id_ex_rt, id_ex_rd}), 32'({5'd2, 5'd3, 5'd4}));
    check("lu_add_val", id_ex_read_data_1, 32'd7);

    // branch resolution
    instruccion = i_type(6'h04, 5'd1, 5'd2, 16'd5);
    pc_in = 11'h010;
    #2;
    check("beq_pcsrc", 32'(PCSrc), 32'd1);
    check("beq_flush", 32'(IF_Flush), 32'd1);
    check("beq_target", 32'(pc_salto), 32'h015);
    check("beq_pcwrite", 32'(PCWrite), 32'd1);
    step();
    check("beq_bubble", ctrl_bits(), 32'h0);
    instruccion = i_type(6'h04, 5'd1, 5'd2, 16'hFFE0);
    #2;
    check("beq_wrap", 32'(pc_salto), 32'h7F0);
    check("beq_wrap_pcsrc", 32'(PCSrc), 32'd1);
    step();
    instruccion = i_type(6'h05, 5'd1, 5'd2, 16'd5);
    #2;
    check("bne_eq_pcsrc", 32'(PCSrc), 32'd0);
    check("bne_eq_flush", 32'(IF_Flush), 32'd0);
    step();
    instruccion = i_type(6'h05, 5'd1, 5'd3, 16'd5);
    #2;
    check("bne_ne_pcsrc", 32'(PCSrc), 32'd1);
    step();
    // WB rewrites $2 in the compare cycle: 7 vs 9 means not taken
    instruccion = i_type(6'h04, 5'd1, 5'd2, 16'd5);
    wb_reg_write = 1'b1; wb_write_reg = 5'd2; wb_write_data = 32'd9;
    #2;
    check("beq_wb_bypass", 32'(PCSrc), 32'd0);
    step();
    wb_reg_write = 1'b0;

    // branch hazard: addi $1 then beq $1,$0 stalls two cycles
    instruccion = i_type(6'h08, 5'd0, 5'd1, 16'd3);
    step();
    check("addi_ctrl", ctrl_bits(), 32'b0100_1000);
    check("addi_imm", id_ex_imm, 32'd3);
    instruccion = i_type(6'h04, 5'd1, 5'd0, 16'd4);
    #2;
    check("bh1_pcwrite", 32'(PCWrite), 32'd0);
    check("bh1_pcsrc", 32'(PCSrc), 32'd0);
    step();
    check("bh1_bubble", ctrl_bits(), 32'h0);
    ex_mem_reg_write = 1'b1; ex_mem_write_reg = 5'd1;
    #2;
    check("bh2_pcwrite", 32'(PCWrite), 32'd0);
    check("bh2_ifid", 32'(IF_ID_Write), 32'd0);
    step();
    ex_mem_reg_write = 1'b0; ex_mem_write_reg = 5'd0;
    wb_reg_write = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'd3;
    #2;
    check("bh_release", 32'(PCWrite), 32'd1);
    check("bh_not_taken", 32'(PCSrc), 32'd0);
    step();
    wb_reg_write = 1'b0;

    // jump
    instruccion = {6'h02, 26'h123};
    #2;
    check("j_target", 32'(pc_salto), 32'h123);
    check("j_pcsrc", 32'(PCSrc), 32'd1);
    check("j_flush", 32'(IF_Flush), 32'd1);
    step();

    // reset during a load-use stall
    instruccion = i_type(6'h23, 5'd1, 5'd2, 16'h0008);
    pc_in = 11'h055;
    step();
    instruccion = r_type(5'd2, 5'd3, 5'd4);
    #2;
    check("rs_stall_pcwrite", 32'(PCWrite), 32'd0);
    reset = 1'b1;
    #2;
    check("rs_force_pcwrite", 32'(PCWrite), 32'd1);
    check("rs_force_ifid", 32'(IF_ID_Write), 32'd1);
    step();
    check("rs_ctrl", ctrl_bits(), 32'h0);
    check("rs_rd1", id_ex_read_data_1, 32'h0);
    check("rs_rd2", id_ex_read_data_2, 32'h0);
    check("rs_imm", id_ex_imm, 32'h0);
    check("rs_fields", 32'({id_ex_rs, id_ex_rt, id_ex_rd}), 32'h0);
    check("rs_pc", 32'(id_ex_pc), 32'h0);
    check("rs_pcwrite", 32'(PCWrite), 32'd1);
    reset = 1'b0;
    instruccion = r_type(5'd1, 5'd2, 5'd4);
    step();
    check("rs_reg1_clear", id_ex_read_data_1, 32'h0);
    check("rs_reg2_clear", id_ex_read_data_2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
